// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the multiply/divide sequencer.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit product and quotient/remainder for the MD unit.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic               a_neg;
    logic               b_neg;
    logic        [31:0] ua;
    logic        [31:0] ub;
    logic        [31:0] uq;
    logic        [31:0] ur;
    logic        [31:0] q;
    logic        [31:0] r;

    // Signed division works on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
    always_comb begin
        sprod    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        uprod    = {32'd0, a} * {32'd0, b};
        a_neg    = (op == MD_DIV) && a[31];
        b_neg    = (op == MD_DIV) && b[31];
        ua       = a_neg ? (~a + 32'd1) : a;
        ub       = b_neg ? (~b + 32'd1) : b;
        div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);
        if (ub == 32'd0) begin
            uq = 32'd0;
            ur = 32'd0;
        end else begin
            uq = ua / ub;
            ur = ua % ub;
        end
        q = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        r = a_neg ? (~ur + 32'd1) : ur;
        case (op)
            MD_MULT:          {hi, lo} = sprod;
            MD_MULTU:         {hi, lo} = uprod;
            MD_DIV, MD_DIVU:  {hi, lo} = {r, q};
            default:          {hi, lo} = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle scheduler for the E-stage multiply/divide unit; owns HI/LO and
// raises ooccupy so the hazard unit stalls dependent instructions.
module md_sequencer
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        istart,
    input  logic [2:0]  iop,
    input  logic [31:0] iA1,
    input  logic [31:0] iA2,
    input  logic        disab,
    output logic [31:0] oHI,
    output logic [31:0] oLO,
    output logic        ooccupy,
    output logic        odone
);

    localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       phi_q, phi_d;
    logic [31:0]       plo_q, plo_d;
    logic              done_q, done_d;

    logic              accept;
    logic              is_md;
    logic              commit;
    logic [31:0]       ar_hi;
    logic [31:0]       ar_lo;
    logic              ar_div_zero;

    md_arith u_arith (
        .op       (iop),
        .a        (iA1),
        .b        (iA2),
        .hi       (ar_hi),
        .lo       (ar_lo),
        .div_zero (ar_div_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        accept  = istart && !disab && (state_q == IDLE);
        is_md   = (iop <= MD_DIVU);
        commit  = (state_q == BUSY) && (cnt_q == CNT_W'(1));
        state_d = state_q;
        if (accept && is_md) begin
            state_d = BUSY;
        end else if (commit) begin
            state_d = IDLE;
        end
    end

    // Divide by zero latches the current HI/LO as the pending result, so the
    // commit edge is a no-op on the architectural registers.
    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        phi_d  = phi_q;
        plo_d  = plo_q;
        done_d = commit;
        if (accept && is_md) begin
            cnt_d = ((iop == MD_MULT) || (iop == MD_MULTU)) ?
                    CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            phi_d = ar_div_zero ? hi_q : ar_hi;
            plo_d = ar_div_zero ? lo_q : ar_lo;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (commit) begin
            hi_d = phi_q;
            lo_d = plo_q;
        end
        if (accept && (iop == MD_MTHI)) begin
            hi_d = iA1;
        end
        if (accept && (iop == MD_MTLO)) begin
            lo_d = iA1;
        end
    end

    always_comb begin
        ooccupy = (state_q == BUSY) || (istart && !disab && (iop <= MD_MTLO));
        odone   = done_q;
        oHI     = hi_q;
        oLO     = lo_q;
    end

endmodule
